// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and switch-input clamping helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_clamp(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0-9) up/down counter with clamped parallel load and carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t q,
    output logic       carry
);

    // Carry (up) or borrow (down) when this step rolls the digit over.
    assign carry = step && (up ? (q == BCD_MAX) : (q == BCD_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_clamp(d);
        end else if (step) begin
            if (up) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            else    q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_up_down_counter.sv
// Two-digit BCD up/down counter with prescaler, clamped load and tick/wrap pulses.
module bcd_up_down_counter
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       En,
    input  logic       Up,
    input  logic       Load,
    input  logic [7:0] D,
    output logic [7:0] Q,
    output logic       Tick,
    output logic       Wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic          tc;
    logic          ones_carry;
    logic          tens_carry;
    bcd_digit_t    ones_q;
    bcd_digit_t    tens_q;

    assign tc = En && (pre == PRE_LAST);

    bcd_digit u_ones (
        .clk   (Clock),
        .rst_n (Resetn),
        .load  (Load),
        .d     (D[3:0]),
        .step  (tc),
        .up    (Up),
        .q     (ones_q),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .clk   (Clock),
        .rst_n (Resetn),
        .load  (Load),
        .d     (D[7:4]),
        .step  (ones_carry),
        .up    (Up),
        .q     (tens_q),
        .carry (tens_carry)
    );

    assign Q = {tens_q, ones_q};

    // Load wins over a coincident step: no pulse, and prescaler phase restarts.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pre  <= '0;
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end else if (Load) begin
            pre  <= '0;
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end else begin
            Tick <= tc;
            Wrap <= tens_carry;
            if (En) pre <= tc ? '0 : pre + PW'(1);
        end
    end

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// Directed bench: decimal-integer model of the counter checked every cycle, plus literal checkpoints.
module tb_bcd_up_down_counter;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b1;
    logic       en4 = 0, up4 = 0, load4 = 0;
    logic [7:0] d4 = 0;
    logic       en1 = 0, up1 = 0, load1 = 0;
    logic [7:0] d1 = 0;
    logic [7:0] q4, q1;
    logic       tick4, wrap4, tick1, wrap1;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    bcd_up_down_counter #(.TICK_DIV(4)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .En(en4), .Up(up4), .Load(load4), .D(d4),
        .Q(q4), .Tick(tick4), .Wrap(wrap4)
    );

    bcd_up_down_counter #(.TICK_DIV(1)) dut1 (
        .Clock(Clock), .Resetn(Resetn), .En(en1), .Up(up1), .Load(load1), .D(d1),
        .Q(q1), .Tick(tick1), .Wrap(wrap1)
    );

    // Model: count held as a plain decimal integer 0..99.
    typedef struct {
        int q;
        int pre;
        bit tick;
        bit wrap;
    } mstate_t;

    mstate_t m4 = '{0, 0, 1'b0, 1'b0};
    mstate_t m1 = '{0, 0, 1'b0, 1'b0};

    function automatic int clamp9(input int n);
        return (n > 9) ? 9 : n;
    endfunction

    function automatic int to_bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    function automatic mstate_t mnext(input mstate_t s, input int div, input bit en,
                                      input bit up, input bit load, input logic [7:0] d);
        mstate_t n;
        int dv;
        n = s;
        n.tick = 1'b0;
        n.wrap = 1'b0;
        dv = int'(d);
        if (load) begin
            n.q   = clamp9(dv / 16) * 10 + clamp9(dv % 16);
            n.pre = 0;
        end else if (en) begin
            if (s.pre == div - 1) begin
                n.pre  = 0;
                n.tick = 1'b1;
                n.q    = up ? (s.q + 1) % 100 : (s.q + 99) % 100;
                n.wrap = up ? (s.q == 99) : (s.q == 0);
            end else begin
                n.pre = s.pre + 1;
            end
        end
        return n;
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m4 <= '{0, 0, 1'b0, 1'b0};
            m1 <= '{0, 0, 1'b0, 1'b0};
        end else begin
            m4 <= mnext(m4, 4, en4, up4, load4, d4);
            m1 <= mnext(m1, 1, en1, up1, load1, d1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge Clock) begin
        chk("q4",    int'(q4),    to_bcd(m4.q));
        chk("tick4", int'(tick4), int'(m4.tick));
        chk("wrap4", int'(wrap4), int'(m4.wrap));
        chk("q1",    int'(q1),    to_bcd(m1.q));
        chk("tick1", int'(tick1), int'(m1.tick));
        chk("wrap1", int'(wrap1), int'(m1.wrap));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Literal checkpoint: pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string name, input int q, input int t, input int w);
        chk({name, " Q"},       int'(q4),    q);
        chk({name, " Tick"},    int'(tick4), t);
        chk({name, " Wrap"},    int'(wrap4), w);
        chk({name, " model Q"}, to_bcd(m4.q), q);
    endtask

    initial begin
        int wraps, ticks, invalid;
        logic [7:0] v;

        #1 Resetn = 1'b0;
        #1 lit("reset", 'h00, 0, 0);
        cyc(2);
        Resetn = 1'b1;

        // Up carry and wrap: 98 -> 99 -> 00
        load4 = 1; d4 = 8'h98; cyc(1);
        lit("load98", 'h98, 0, 0);
        load4 = 0; en4 = 1; up4 = 1;
        cyc(3); lit("pre-step", 'h98, 0, 0);
        cyc(1); lit("step99", 'h99, 1, 0);
        cyc(4); lit("wrap00", 'h00, 1, 1);
        cyc(1); lit("after wrap", 'h00, 0, 0);

        // Down borrow and wrap: 10 -> 09 ... 00 -> 99
        load4 = 1; d4 = 8'h10; cyc(1);
        load4 = 0; up4 = 0;
        cyc(4);  lit("borrow09", 'h09, 1, 0);
        cyc(36); lit("down00", 'h00, 1, 0);
        cyc(4);  lit("wrap99", 'h99, 1, 1);

        // Load clamp with priority over a coincident step
        cyc(3); load4 = 1; d4 = 8'hAF;
        cyc(1); lit("clampAF", 'h99, 0, 0);
        load4 = 0;
        cyc(3); lit("no early step", 'h99, 0, 0);
        cyc(1); lit("step after load", 'h98, 1, 0);

        // En freeze with prescaler at 2
        cyc(2); en4 = 0;
        cyc(10); lit("frozen", 'h98, 0, 0);
        en4 = 1;
        cyc(1); lit("resume1", 'h98, 0, 0);
        cyc(1); lit("resume2", 'h97, 1, 0);

        // Reset mid-count at 37, asserted between edges
        load4 = 1; d4 = 8'h36; up4 = 1; cyc(1);
        load4 = 0;
        cyc(4); lit("at37", 'h37, 1, 0);
        #2 Resetn = 1'b0;
        #1 lit("async reset", 'h00, 0, 0);
        cyc(3); Resetn = 1'b1;
        cyc(3); lit("post reset idle", 'h00, 0, 0);
        cyc(1); lit("post reset step", 'h01, 1, 0);
        en4 = 0;

        // Exhaustive walk on TICK_DIV = 1
        wraps = 0; ticks = 0; invalid = 0;
        en1 = 1; up1 = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            v = q1;
            if (v[7:4] > 4'd9 || v[3:0] > 4'd9) invalid++;
            if (wrap1) wraps++;
            if (tick1) ticks++;
        end
        en1 = 0;
        chk("walk invalid", invalid, 0);
        chk("walk wraps", wraps, 2);
        chk("walk ticks", ticks, 200);
        chk("walk final", int'(q1), 'h00);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_up_down_counter.md
# bcd_up_down_counter

Two-digit BCD up/down counter that produces the tens/ones digit pair consumed directly by the board's 7-segment decoder stage (tens to HEX1 decoder, ones to HEX0 decoder). Includes an internal prescaler so a fast board clock advances the count at a human-visible rate. Supports parallel load from the slide switches, with BCD clamping. Emits single-cycle tick and wrap pulses for LED indication or chaining.

## Interface
- TICK_DIV, 50_000_000: Clock cycles per count step; legal range 1 to 2^26.
- Clock  input  1  board clock; all state changes on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- En  input  1  1 = prescaler runs and count advances; 0 = freeze everything except load.
- Up  input  1  1 = count up, 0 = count down; sampled on the step cycle.
- Load  input  1  synchronous parallel load of D.
- D  input  8  load value; D[7:4] tens, D[3:0] ones (switch bank).
- Q  output  8  current count; Q[7:4] tens BCD, Q[3:0] ones BCD; each nibble always 0–9.
- Tick  output  1  one-cycle pulse, high in the first cycle a stepped value is visible on Q.
- Wrap  output  1  one-cycle pulse, high with Tick when the step crossed 99→00 (up) or 00→99 (down).

## Operation
- Reset (Resetn low, any time, no clock needed): Q = 8'h00, prescaler = 0, Tick = 0, Wrap = 0. This is held until Resetn deasserts. The first edge after deassertion behaves as a normal cycle.
- Prescaler: counts 0 … TICK_DIV-1 while En = 1. A step fires on the edge where prescaler == TICK_DIV-1 and En = 1, and the prescaler returns to 0 on that edge. With En = 0 the prescaler holds its value and no step fires.
- Step, up:
  - ones 0–8: ones+1.
  - ones 9: ones→0, and tens+1.
  - tens 9 with ones 9: Q→00, Wrap = 1.
- Step, down:
  - ones 1–9: ones-1.
  - ones 0: ones→9, and tens-1.
  - Q = 00: Q→99, Wrap = 1.
- Load = 1 has priority over a step and ignores En. On load:
  - Q ← D, with any nibble > 9 clamped to 9 (for example D = 8'hA3 loads 8'h93).
  - Prescaler ← 0.
  - Tick = 0, Wrap = 0 for that edge, even if a step would have fired.
- Up changing between steps has no effect until the next step. Changing Up on the step cycle uses the sampled value.
- TICK_DIV = 1: a step fires on every enabled cycle and Tick stays high continuously.
- All arithmetic is per-nibble modulo 10. Binary values 10–15 never appear on Q.

## Timing
- All outputs are registered. There is no combinational path from any input to Q, Tick or Wrap.
- Step latency: Q changes on the edge where the prescaler reaches TICK_DIV-1. Tick and Wrap are high for exactly the following cycle.
- Load latency: Q = clamped D one edge after Load is sampled high. A held Load reloads every cycle and keeps the prescaler at 0.
- Steps are spaced exactly TICK_DIV cycles apart under continuous En = 1.
- Deasserting En for N cycles delays the next step by N cycles, because the prescaler phase is preserved.
- The downstream decoder is purely combinational, so the displayed digit tracks Q within the same cycle.

## Structure
- The shared package `bcd_pkg` holds:
  - typedef `bcd_digit_t` (logic [3:0]);
  - constants `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0;
  - function `bcd_clamp` (nibble > 9 → 9).
- The natural sub-module is `bcd_digit`: one decade counter with inputs clk, rst_n, load, d, step, up, and output carry/borrow. It is instantiated twice:
  - ones: step = prescaler terminal count;
  - tens: step = ones carry/borrow.
- The prescaler width is $clog2(TICK_DIV) (minimum 1) and lives in the top level.

## Test plan
- Reset mid-count: with TICK_DIV = 4, reach Q = 8'h37, then pulse Resetn low between edges → Q = 8'h00 and Tick = Wrap = 0 immediately. The first step comes 4 cycles after release.
- Up carry and wrap: TICK_DIV = 4, load 8'h98, Up = 1:
  - two steps give Q = 8'h99, then 8'h00;
  - Wrap is high only in the cycle after the 99→00 step;
  - Tick pulses every 4 cycles.
- Down borrow and wrap: load 8'h10, Up = 0:
  - steps give 8'h09, 8'h08, …, 8'h00, then 8'h99 with Wrap = 1;
  - the 8'h10→8'h09 step has Wrap = 0.
- Load clamp and priority: assert Load with D = 8'hAF on the same edge as a step → Q = 8'h99 and Tick = 0. The next step occurs TICK_DIV cycles later.
- En freeze: En = 0 for 10 cycles with the prescaler at 2 (TICK_DIV = 4) → Q unchanged. After En = 1, the step comes exactly 2 enabled cycles later.
- Exhaustive walk: TICK_DIV = 1, Up = 1, run 200 cycles → Q is always valid BCD, 100 consecutive values per period, and Wrap pulses exactly twice.
